// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Bundles the hazard-relevant fields of the ID/EX stages together with the
//   stall/flush controls and performance counters returned by the hazard
//   controller.
//
//   master : pipeline datapath side (drives instruction fields, consumes controls)
//   slave  : hazard controller side (consumes fields, drives controls)
//
//   opcodeD       opcode held in IF/ID
//   rsD, rtD      source register fields of the instruction in ID
//   memreadE      instruction in EX is a load
//   rtE           destination register of the load in EX
//   branch_takenE branch in EX resolved taken this cycle
//   stallF        hold PC
//   stallD        hold IF/ID
//   refresh1      flush IF/ID (bubble)
//   refresh       flush ID/EX (bubble)
//   halted        pipeline drained and frozen (registered)
//   stall_cnt     saturating count of load-use stall cycles
//   flush_cnt     saturating count of branch/jump flush cycles
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       opcodeD;
  logic [4:0]       rsD;
  logic [4:0]       rtD;
  logic             memreadE;
  logic [4:0]       rtE;
  logic             branch_takenE;
  logic             stallF;
  logic             stallD;
  logic             refresh1;
  logic             refresh;
  logic             halted;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output opcodeD, rsD, rtD, memreadE, rtE, branch_takenE,
    input  stallF, stallD, refresh1, refresh, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  opcodeD, rsD, rtD, memreadE, rtE, branch_takenE,
    output stallF, stallD, refresh1, refresh, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and sequencing controller for a 5-stage pipeline.
//   - Load-use hazards stall PC and IF/ID for one cycle and bubble ID/EX.
//   - Taken branches (resolved in EX) flush IF/ID and ID/EX.
//   - Jumps (resolved in ID) squash the fall-through fetch in IF/ID.
//   - A HALT opcode in ID drains the pipeline for DRAIN_CYCLES bubble cycles,
//     then freezes fetch permanently (until reset) and raises halted.
//   - Saturating counters of stall cycles and flush cycles.
//
// Parameters
//   HALT_OP      opcode that starts the halt/drain sequence
//   DRAIN_CYCLES bubble cycles after HALT leaves ID (>= 1)
//   CNT_W        counter width (must match the interface CNT_W)
//
// Ports
//   clk    system clock, all state on posedge
//   reset  synchronous, active-high; forces RUN and zeroes all controls
//   bus    pipe_hazard_ctrl_if.slave (see interface file for signal list)
//
// stallF/stallD/refresh1/refresh are combinational from state and inputs;
// halted, stall_cnt and flush_cnt are registered.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter logic [5:0] HALT_OP      = 6'h3F,
  parameter int         DRAIN_CYCLES = 4,
  parameter int         CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [1:0]         state_q;
  logic [1:0]         state_nxt;
  logic [DRAIN_W-1:0] drain_q;
  logic [DRAIN_W-1:0] drain_nxt;
  logic               halted_q;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   flush_cnt_q;

  logic lu;
  logic jmp;
  logic halt_req;

  logic stall_f;
  logic stall_d;
  logic flush_d;
  logic flush_e;
  logic inc_stall;
  logic inc_flush;

  // Hazard detection on the current ID/EX contents. A load into r0 never
  // creates a dependency since r0 is hardwired to zero.
  always_comb begin
    lu       = bus.memreadE && (bus.rtE != 5'd0) &&
               ((bus.rtE == bus.rsD) || (bus.rtE == bus.rtD));
    jmp      = (bus.opcodeD == OP_J) || (bus.opcodeD == OP_JAL);
    halt_req = (bus.opcodeD == HALT_OP);
  end

  // Control decode and next-state. Everything is forced to zero while
  // reset is asserted so the pipeline sees no stall/flush during reset.
  always_comb begin
    stall_f   = 1'b0;
    stall_d   = 1'b0;
    flush_d   = 1'b0;
    flush_e   = 1'b0;
    inc_stall = 1'b0;
    inc_flush = 1'b0;
    state_nxt = state_q;
    drain_nxt = drain_q;

    if (!reset) begin
      case (state_q)
        ST_RUN: begin
          if (bus.branch_takenE) begin
            // Wrong-path instructions in IF/ID and ID/EX are discarded;
            // whatever hazard they carried no longer matters.
            flush_d   = 1'b1;
            flush_e   = 1'b1;
            inc_flush = 1'b1;
          end else if (lu) begin
            // Hold the consumer in ID one cycle; a jump sitting in ID is
            // held too and gets its flush on the following cycle.
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            flush_e   = 1'b1;
            inc_stall = 1'b1;
          end else if (jmp) begin
            flush_d   = 1'b1;
            inc_flush = 1'b1;
          end else if (halt_req) begin
            state_nxt = ST_DRAIN;
            drain_nxt = DRAIN_W'(DRAIN_CYCLES);
          end
        end

        ST_DRAIN: begin
          // Freeze fetch and feed bubbles while older work retires.
          stall_f   = 1'b1;
          flush_d   = 1'b1;
          drain_nxt = drain_q - DRAIN_W'(1);
          if (drain_q <= DRAIN_W'(1)) begin
            state_nxt = ST_HALTED;
          end
        end

        ST_HALTED: begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          flush_e = 1'b1;
        end

        default: begin
          state_nxt = ST_RUN;
          drain_nxt = '0;
        end
      endcase
    end
  end

  // Registered state, halt flag and performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      drain_q     <= '0;
      halted_q    <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q  <= state_nxt;
      drain_q  <= drain_nxt;
      halted_q <= (state_nxt == ST_HALTED);
      if (inc_stall) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
      if (inc_flush) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end
    end
  end

  assign bus.stallF    = stall_f;
  assign bus.stallD    = stall_d;
  assign bus.refresh1  = flush_d;
  assign bus.refresh   = flush_e;
  assign bus.halted    = halted_q;
  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  logic clk;
  logic reset;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus();

  pipe_hazard_ctrl #(
    .HALT_OP     (6'h3F),
    .DRAIN_CYCLES(4),
    .CNT_W       (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nchecks = 0;
  int nerr    = 0;

  typedef struct {
    logic       br;
    logic       mr;
    logic [4:0] rte;
    logic [4:0] rsd;
    logic [4:0] rtd;
    logic [5:0] op;
    logic [3:0] ctl;   // {stallF, stallD, refresh1, refresh}
    logic [3:0] scnt;  // stall_cnt after the edge
    logic [3:0] fcnt;  // flush_cnt after the edge
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic br, input logic mr, input logic [4:0] rte,
                       input logic [4:0] rsd, input logic [4:0] rtd, input logic [5:0] op);
    bus.branch_takenE = br;
    bus.memreadE      = mr;
    bus.rtE           = rte;
    bus.rsD           = rsd;
    bus.rtD           = rtd;
    bus.opcodeD       = op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] ctl();
    return {bus.stallF, bus.stallD, bus.refresh1, bus.refresh};
  endfunction

  initial begin
    // br mr rtE rsD rtD op     ctl     scnt fcnt
    vecs[0]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 6'h00, 4'b0000, 4'd0, 4'd0};
    vecs[1]  = '{1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 6'h00, 4'b0000, 4'd0, 4'd0};
    vecs[2]  = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 6'h00, 4'b1101, 4'd1, 4'd0};
    vecs[3]  = '{1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 6'h00, 4'b0000, 4'd1, 4'd0};
    vecs[4]  = '{1'b0, 1'b1, 5'd7, 5'd3, 5'd7, 6'h00, 4'b1101, 4'd2, 4'd0};
    vecs[5]  = '{1'b0, 1'b1, 5'd7, 5'd3, 5'd4, 6'h00, 4'b0000, 4'd2, 4'd0};
    vecs[6]  = '{1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 6'h00, 4'b0011, 4'd2, 4'd1};
    vecs[7]  = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 6'h02, 4'b1101, 4'd3, 4'd1};
    vecs[8]  = '{1'b0, 1'b0, 5'd5, 5'd5, 5'd0, 6'h02, 4'b0010, 4'd3, 4'd2};
    vecs[9]  = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 6'h03, 4'b0010, 4'd3, 4'd3};
    vecs[10] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 6'h02, 4'b0011, 4'd3, 4'd4};
    vecs[11] = '{1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 6'h3F, 4'b0011, 4'd3, 4'd5};
    vecs[12] = '{1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 6'h3F, 4'b1101, 4'd4, 4'd5};
    vecs[13] = '{1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 6'h00, 4'b0000, 4'd4, 4'd5};

    // Reset: controls zero even with a load-use pattern present.
    reset = 1'b1;
    drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 6'h02);
    #1;
    check("reset_ctl", 32'(ctl()), 32'h0);
    tick();
    tick();
    check("reset_ctl_held", 32'(ctl()), 32'h0);
    check("reset_halted", 32'(bus.halted), 32'h0);
    check("reset_stall_cnt", 32'(bus.stall_cnt), 32'h0);
    check("reset_flush_cnt", 32'(bus.flush_cnt), 32'h0);
    reset = 1'b0;

    // Table-driven RUN vectors.
    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].br, vecs[i].mr, vecs[i].rte, vecs[i].rsd, vecs[i].rtd, vecs[i].op);
      #1;
      check($sformatf("vec%0d_ctl", i), 32'(ctl()), 32'(vecs[i].ctl));
      tick();
      check($sformatf("vec%0d_stall_cnt", i), 32'(bus.stall_cnt), 32'(vecs[i].scnt));
      check($sformatf("vec%0d_flush_cnt", i), 32'(bus.flush_cnt), 32'(vecs[i].fcnt));
      check($sformatf("vec%0d_halted", i), 32'(bus.halted), 32'h0);
    end

    // HALT: one quiet cycle, four drain cycles, then frozen.
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 6'h3F);
    #1;
    check("halt_issue_ctl", 32'(ctl()), 32'h0);
    tick();
    for (int d = 1; d <= 4; d++) begin
      // hazards and branches present but must be ignored while draining
      drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 6'h02);
      #1;
      check($sformatf("drain%0d_ctl", d), 32'(ctl()), 32'b1010);
      check($sformatf("drain%0d_halted", d), 32'(bus.halted), 32'h0);
      tick();
    end
    for (int h = 0; h < 3; h++) begin
      drive(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 6'h02);
      #1;
      check($sformatf("halted%0d_flag", h), 32'(bus.halted), 32'h1);
      check($sformatf("halted%0d_ctl", h), 32'(ctl()), 32'b1101);
      tick();
    end
    check("halt_stall_cnt_frozen", 32'(bus.stall_cnt), 32'd4);
    check("halt_flush_cnt_frozen", 32'(bus.flush_cnt), 32'd5);

    // Reset leaves HALTED; then reset in drain cycle 2 returns to RUN.
    reset = 1'b1;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 6'h00);
    tick();
    check("rst_halted_clear", 32'(bus.halted), 32'h0);
    check("rst_cnt_clear", 32'(bus.stall_cnt), 32'h0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 6'h3F);
    tick();
    drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 6'h00);
    #1;
    check("mid_drain1_ctl", 32'(ctl()), 32'b1010);
    tick();
    reset = 1'b1;
    #1;
    check("mid_drain2_reset_ctl", 32'(ctl()), 32'h0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("post_rst%0d_ctl", k), 32'(ctl()), 32'h0);
      check($sformatf("post_rst%0d_halted", k), 32'(bus.halted), 32'h0);
      tick();
    end
    drive(1'b0, 1'b1, 5'd9, 5'd0, 5'd9, 6'h00);
    #1;
    check("post_rst_lu_ctl", 32'(ctl()), 32'b1101);
    tick();

    // Saturation: 19 stall events, then 19 flush events, on a 4-bit counter.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      drive(1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 6'h00);
      tick();
      check($sformatf("sat_stall%0d", i), 32'(bus.stall_cnt), (i > 15) ? 32'd15 : 32'(i));
    end
    for (int i = 1; i <= 19; i++) begin
      drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 6'h02);
      tick();
      check($sformatf("sat_flush%0d", i), 32'(bus.flush_cnt), (i > 15) ? 32'd15 : 32'(i));
    end
    check("sat_stall_final", 32'(bus.stall_cnt), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end

endmodule
